// File: rtl/sw_prio_encoder_if.sv
// Switch-encoder bus: raw switch vector in, debounced priority code and
// LED image out. The master modport is the encoder side, the slave modport
// is the switch/display side.
interface sw_prio_encoder_if #(
  parameter int WIDTH = 4
);
  localparam int CODE_W = $clog2(WIDTH);

  logic [WIDTH-1:0]  sw;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic              multi;
  logic [WIDTH-1:0]  onehot;
  logic              changed;

  modport master (
    input  sw,
    output code, valid, multi, onehot, changed
  );

  modport slave (
    output sw,
    input  code, valid, multi, onehot, changed
  );
endinterface

// File: rtl/sw_prio_encoder.sv
// sw_prio_encoder: synchronises WIDTH raw switches, debounces the whole
// vector with a single saturating counter and registers a highest-priority
// binary code with valid/multi flags, a one-hot LED image and a change strobe.
// Optional macro ENC_HOLD_EN: when the debounced vector goes all-zero, code
// and onehot keep their last valid values (sticky LED) while valid/multi drop.
module sw_prio_encoder #(
  parameter int WIDTH      = 4,
  parameter int DEB_CYCLES = 240000
) (
  input  logic               clk,
  input  logic               rst_n,
  sw_prio_encoder_if.master  bus
);

  localparam int CODE_W = $clog2(WIDTH);
  localparam int CNT_W  = $clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  // Index of the highest set bit; 0 for an all-zero vector.
  function automatic logic [CODE_W-1:0] hi_index(input logic [WIDTH-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

  // True when more than one bit is set: clearing the lowest set bit leaves
  // something behind.
  function automatic logic more_than_one(input logic [WIDTH-1:0] v);
    return |(v & (v - WIDTH'(1)));
  endfunction

  function automatic logic [WIDTH-1:0] onehot_of(input logic [CODE_W-1:0] c);
    logic [WIDTH-1:0] r;
    r    = '0;
    r[c] = 1'b1;
    return r;
  endfunction

  logic [WIDTH-1:0]  s1;
  logic [WIDTH-1:0]  s2;
  logic [WIDTH-1:0]  cand;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  stable;

  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic              multi_q;
  logic [WIDTH-1:0]  onehot_q;
  logic              changed_q;

  logic              enc_valid;
  logic              enc_multi;
  logic [CODE_W-1:0] nxt_code;
  logic [WIDTH-1:0]  nxt_onehot;

  // Two-flop synchroniser; only s2 is safe to use downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.sw;
      s2 <= s1;
    end
  end

  // Whole-vector debouncer: any difference restarts the count, and the
  // candidate is accepted once it has matched for DEB_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else if (s2 != cand) begin
      cand <= s2;
      cnt  <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= cand;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Next-state encoder outputs derived from the debounced vector.
  always_comb begin
    enc_valid = |stable;
    enc_multi = more_than_one(stable);
`ifdef ENC_HOLD_EN
    nxt_code   = enc_valid ? hi_index(stable) : code_q;
    nxt_onehot = enc_valid ? onehot_of(hi_index(stable)) : onehot_q;
`else
    nxt_code   = hi_index(stable);
    nxt_onehot = enc_valid ? onehot_of(hi_index(stable)) : '0;
`endif
  end

  // Output register; changed flags a difference in {valid, code} only, so a
  // multi-only change stays silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q    <= '0;
      valid_q   <= 1'b0;
      multi_q   <= 1'b0;
      onehot_q  <= '0;
      changed_q <= 1'b0;
    end else begin
      code_q    <= nxt_code;
      valid_q   <= enc_valid;
      multi_q   <= enc_multi;
      onehot_q  <= nxt_onehot;
      changed_q <= ({enc_valid, nxt_code} != {valid_q, code_q});
    end
  end

  assign bus.code    = code_q;
  assign bus.valid   = valid_q;
  assign bus.multi   = multi_q;
  assign bus.onehot  = onehot_q;
  assign bus.changed = changed_q;

endmodule

// File: tb/tb_sw_prio_encoder.sv
// Directed bench for sw_prio_encoder (WIDTH=4, DEB_CYCLES=4). Stimulus pushes
// the expected changed-pulse contents and cycle into a scoreboard queue; a
// monitor pops and compares whenever changed is seen.
module tb_sw_prio_encoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cycle = 0;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct {
    int         cyc;
    logic [1:0] code;
    logic       valid;
    logic       multi;
    logic [3:0] onehot;
  } exp_t;

  exp_t sbq[$];
  logic [7:0] prev_out = 8'h00;

  sw_prio_encoder_if #(.WIDTH(4)) bus();

  sw_prio_encoder #(.WIDTH(4), .DEB_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [7:0] pack(input logic [1:0] c, input logic v,
                                      input logic m, input logic [3:0] o);
    return {c, v, m, o};
  endfunction

  task automatic chk(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = pack(bus.code, bus.valid, bus.multi, bus.onehot);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: {code,valid,multi,onehot} got %b required %b", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // Apply a held vector; check old outputs at edge 7 and new ones at edge 8.
  task automatic settle(input string name, input logic [3:0] v, input logic [1:0] ec,
                        input logic ev, input logic em, input logic [3:0] eo,
                        input logic ep);
    int c;
    exp_t e;
    @(negedge clk);
    bus.sw = v;
    c = cycle;
    if (ep) begin
      e = '{cyc: c + 8, code: ec, valid: ev, multi: em, onehot: eo};
      sbq.push_back(e);
    end
    repeat (7) @(posedge clk);
    #1 chk({name, "_edge7"}, prev_out);
    @(posedge clk);
    #1 chk({name, "_edge8"}, pack(ec, ev, em, eo));
    prev_out = pack(ec, ev, em, eo);
    repeat (4) @(posedge clk);
  endtask

  // Short pulse on sw that must be rejected by the debouncer.
  task automatic glitch(input string name, input logic [3:0] v, input int n);
    @(negedge clk);
    bus.sw = v;
    repeat (n) @(negedge clk);
    bus.sw = 4'b0000;
    repeat (14) @(posedge clk);
    #1 chk(name, prev_out);
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.changed === 1'b1) begin
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL changed_unexpected: pulse at cycle %0d out=%b required no pulse",
                   cycle, pack(bus.code, bus.valid, bus.multi, bus.onehot));
        end else begin
          e = sbq.pop_front();
          if (e.cyc != cycle ||
              pack(bus.code, bus.valid, bus.multi, bus.onehot) !==
              pack(e.code, e.valid, e.multi, e.onehot)) begin
            miscompares++;
            $display("FAIL changed_pulse: cycle %0d out=%b required cycle %0d out=%b",
                     cycle, pack(bus.code, bus.valid, bus.multi, bus.onehot),
                     e.cyc, pack(e.code, e.valid, e.multi, e.onehot));
          end
        end
      end else if (sbq.size() > 0 && sbq[0].cyc < cycle) begin
        vectors++;
        miscompares++;
        $display("FAIL changed_missing: no pulse by cycle %0d required at cycle %0d",
                 cycle, sbq[0].cyc);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] z_code;
    logic [3:0] z_onehot;
    bus.sw = 4'b1111;

    // 1: asynchronous reset before any clock edge, then idle with sw=0000.
    #1 rst_n = 1'b0;
    #2 chk("reset_async", 8'h00);
    chk_bit("reset_changed", bus.changed, 1'b0);
    @(negedge clk);
    bus.sw = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("idle_after_release", 8'h00);

    // 2: single switch.
    settle("sw_0010", 4'b0010, 2'd1, 1'b1, 1'b0, 4'b0010, 1'b1);
    // 3: higher switch added, then a lower one that does not move the code.
    settle("sw_1010", 4'b1010, 2'd3, 1'b1, 1'b1, 4'b1000, 1'b1);
    settle("sw_1011", 4'b1011, 2'd3, 1'b1, 1'b1, 4'b1000, 1'b0);
    // multi-only changes stay silent.
    settle("sw_0100", 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0100, 1'b1);
    settle("sw_0110", 4'b0110, 2'd2, 1'b1, 1'b1, 4'b0100, 1'b0);
    settle("sw_0100b", 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0100, 1'b0);

    // 5: all switches released.
`ifdef ENC_HOLD_EN
    z_code   = 2'd2;
    z_onehot = 4'b0100;
`else
    z_code   = 2'd0;
    z_onehot = 4'b0000;
`endif
    settle("sw_0000", 4'b0000, z_code, 1'b0, 1'b0, z_onehot, 1'b1);

    // 4: glitches of 3 cycles and of DEB_CYCLES cycles (longest still too short).
    glitch("glitch_3", 4'b0001, 3);
    glitch("glitch_4", 4'b0001, 4);

    settle("sw_0001", 4'b0001, 2'd0, 1'b1, 1'b0, 4'b0001, 1'b1);

    // 6: reset in the middle of a debounce.
    begin
      int   c;
      exp_t e;
      @(negedge clk);
      bus.sw = 4'b1000;
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      #1 chk("reset_mid_debounce", 8'h00);
      chk_bit("reset_mid_changed", bus.changed, 1'b0);
      #2 rst_n = 1'b1;
      c = cycle;
      prev_out = 8'h00;
      e = '{cyc: c + 8, code: 2'd3, valid: 1'b1, multi: 1'b0, onehot: 4'b1000};
      sbq.push_back(e);
      repeat (7) @(posedge clk);
      #1 chk("after_reset_edge7", prev_out);
      @(posedge clk);
      #1 chk("after_reset_edge8", pack(2'd3, 1'b1, 1'b0, 4'b1000));
      repeat (6) @(posedge clk);
    end

    #1;
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d pulses outstanding, required 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
